// File: rtl/l1i_pkg.sv
// Shared widths, address-field helpers and line-entry layout for the L1 instruction cache.
package l1i_pkg;

   localparam int unsigned ADDR_W       = 64;
   localparam int unsigned LINE_W       = 512;
   localparam int unsigned INST_W       = 32;
   localparam int unsigned OFFSET_W     = 6;
   localparam int unsigned INDEX_W      = 8;
   localparam int unsigned TAG_W        = 62;
   localparam int unsigned PID_W        = 32;
   localparam int unsigned TID_W        = 64;
   localparam int unsigned MAJ_W        = 64;

   localparam int unsigned ADDR_TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
   localparam int unsigned NUM_LINES    = 1 << INDEX_W;
   localparam int unsigned LINE_INSTS   = LINE_W / INST_W;
   localparam int unsigned SLOT_W       = $clog2(LINE_INSTS);
   localparam int unsigned INST_BYTE_W  = $clog2(INST_W / 8);
   localparam int unsigned BUNDLE_INSTS = 4;
   localparam int unsigned BUNDLE_W     = BUNDLE_INSTS * INST_W;
   localparam int unsigned LEN_W        = 2;
   localparam int unsigned INC_W        = 3;

   typedef logic [LINE_INSTS-1:0][INST_W-1:0]   line_data_t;
   typedef logic [BUNDLE_INSTS-1:0][INST_W-1:0] bundle_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [PID_W-1:0] pid;
      logic [TID_W-1:0] tid;
      line_data_t       data;
   } line_entry_t;

   // Upper address bits, zero-extended into the stored tag width
   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
      return TAG_W'(a[ADDR_W-1 -: ADDR_TAG_W]);
   endfunction

   function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
      return a[OFFSET_W +: INDEX_W];
   endfunction

   function automatic logic [SLOT_W-1:0] addr_slot(input logic [ADDR_W-1:0] a);
      return a[INST_BYTE_W +: SLOT_W];
   endfunction

endpackage

// File: rtl/l1i_line_store.sv
// Line storage: one combinational read port, two write ports (A has priority on a shared index)
// and a single-cycle invalidate of every line.
module l1i_line_store
   import l1i_pkg::*;
(
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic                inval_i,
   input  logic [INDEX_W-1:0]  rd_index_i,
   output logic                rd_valid_c_o,
   output line_entry_t         rd_entry_c_o,
   input  logic                wa_en_i,
   input  logic [INDEX_W-1:0]  wa_index_i,
   input  line_entry_t         wa_entry_i,
   input  logic                wb_en_i,
   input  logic [INDEX_W-1:0]  wb_index_i,
   input  line_entry_t         wb_entry_i
);

   logic [NUM_LINES-1:0] valid_q;
   line_entry_t          entry_q [NUM_LINES];

   logic wb_blocked_c;
   assign wb_blocked_c = wa_en_i & (wa_index_i == wb_index_i);

   // Invalidate overrides any write landing in the same cycle
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         valid_q <= '0;
      end else if (inval_i) begin
         valid_q <= '0;
      end else begin
         if (wb_en_i) valid_q[wb_index_i] <= 1'b1;
         if (wa_en_i) valid_q[wa_index_i] <= 1'b1;
      end
   end

   always_ff @(posedge clock_i) begin
      if (wb_en_i && !wb_blocked_c) entry_q[wb_index_i] <= wb_entry_i;
      if (wa_en_i)                  entry_q[wa_index_i] <= wa_entry_i;
   end

   assign rd_valid_c_o = valid_q[rd_index_i];
   assign rd_entry_c_o = entry_q[rd_index_i];

endmodule

// File: rtl/l1i_cache.sv
// Direct-mapped L1 instruction cache: one-cycle lookup returning up to four instructions
// stamped with a running major ID, plus miss reporting and PC-increment override.
module l1i_cache
   import l1i_pkg::*;
(
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic                 fetchEnable_i,
   input  logic                 cacheReset_i,
   input  logic                 fetchStall_i,
   input  logic [PID_W-1:0]     Pid_i,
   input  logic [TID_W-1:0]     Tid_i,
   input  logic [ADDR_W-1:0]    fetchAddress_i,
   input  logic                 cacheUpdate_i,
   input  logic [ADDR_W-1:0]    cacheUpdateAddress_i,
   input  logic [PID_W-1:0]     cacheUpdatePid_i,
   input  logic [TID_W-1:0]     cacheUpdateTid_i,
   input  logic [MAJ_W-1:0]     missedInstMajorId_i,
   input  logic [LINE_W-1:0]    cacheUpdateLine_i,
   input  logic                 naturalWriteEn_i,
   input  logic [ADDR_W-1:0]    naturalWriteAddress_i,
   input  logic [LINE_W-1:0]    naturalWriteLine_i,
   input  logic [PID_W-1:0]     naturalPid_i,
   input  logic [TID_W-1:0]     naturalTid_i,
   output logic                 icachePCIncEnable_o,
   output logic [INC_W-1:0]     iCachePCIncVal_o,
   output logic                 outputEnable_o,
   output logic [BUNDLE_W-1:0]  outputBundle_o,
   output logic [ADDR_W-1:0]    bundleAddress_o,
   output logic [LEN_W-1:0]     bundleLen_o,
   output logic [PID_W-1:0]     bundlePid_o,
   output logic [TID_W-1:0]     bundleTid_o,
   output logic [MAJ_W-1:0]     bundleStartMajId_o,
   output logic                 cacheMiss_o,
   output logic [ADDR_W-1:0]    missedAddress_o,
   output logic [MAJ_W-1:0]     missedInstMajorId_o,
   output logic [PID_W-1:0]     missedPid_o,
   output logic [TID_W-1:0]     missedTid_o
);

   logic        rd_valid_c;
   line_entry_t rd_entry_c;
   line_entry_t upd_entry_c;
   line_entry_t nat_entry_c;

   assign upd_entry_c = '{tag:  addr_tag(cacheUpdateAddress_i),
                          pid:  cacheUpdatePid_i,
                          tid:  cacheUpdateTid_i,
                          data: line_data_t'(cacheUpdateLine_i)};
   assign nat_entry_c = '{tag:  addr_tag(naturalWriteAddress_i),
                          pid:  naturalPid_i,
                          tid:  naturalTid_i,
                          data: line_data_t'(naturalWriteLine_i)};

   l1i_line_store u_store (
      .clock_i      (clock_i),
      .reset_i      (reset_i),
      .inval_i      (cacheReset_i),
      .rd_index_i   (addr_index(fetchAddress_i)),
      .rd_valid_c_o (rd_valid_c),
      .rd_entry_c_o (rd_entry_c),
      .wa_en_i      (cacheUpdate_i),
      .wa_index_i   (addr_index(cacheUpdateAddress_i)),
      .wa_entry_i   (upd_entry_c),
      .wb_en_i      (naturalWriteEn_i),
      .wb_index_i   (addr_index(naturalWriteAddress_i)),
      .wb_entry_i   (nat_entry_c)
   );

   logic                lookup_c;
   logic                hit_c;
   logic [SLOT_W-1:0]   slot_c;
   logic [SLOT_W:0]     avail_c;
   logic [INC_W-1:0]    n_c;
   bundle_t             bundle_c;

   assign lookup_c = fetchEnable_i & ~fetchStall_i;
   assign hit_c    = lookup_c & rd_valid_c
                   & (rd_entry_c.tag == addr_tag(fetchAddress_i))
                   & (rd_entry_c.pid == Pid_i)
                   & (rd_entry_c.tid == Tid_i);

   // Bundle is clipped at the end of the line
   assign slot_c  = addr_slot(fetchAddress_i);
   assign avail_c = (SLOT_W+1)'(LINE_INSTS) - {1'b0, slot_c};
   assign n_c     = (avail_c >= (SLOT_W+1)'(BUNDLE_INSTS)) ? INC_W'(BUNDLE_INSTS) : INC_W'(avail_c);

   always_comb begin
      bundle_c = '0;
      for (int unsigned j = 0; j < BUNDLE_INSTS; j++) begin
         if (INC_W'(j) < n_c) bundle_c[j] = rd_entry_c.data[slot_c + SLOT_W'(j)];
      end
   end

   logic                pc_inc_en_q,  pc_inc_en_d;
   logic [INC_W-1:0]    pc_inc_val_q, pc_inc_val_d;
   logic                out_en_q,     out_en_d;
   bundle_t             bundle_q,     bundle_d;
   logic [ADDR_W-1:0]   baddr_q,      baddr_d;
   logic [LEN_W-1:0]    blen_q,       blen_d;
   logic [PID_W-1:0]    bpid_q,       bpid_d;
   logic [TID_W-1:0]    btid_q,       btid_d;
   logic [MAJ_W-1:0]    bmaj_q,       bmaj_d;
   logic                miss_q,       miss_d;
   logic [ADDR_W-1:0]   maddr_q,      maddr_d;
   logic [MAJ_W-1:0]    mmaj_q,       mmaj_d;
   logic [PID_W-1:0]    mpid_q,       mpid_d;
   logic [TID_W-1:0]    mtid_q,       mtid_d;
   logic [MAJ_W-1:0]    ctr_q,        ctr_d;

   // Data outputs hold unless their event fires; a refill load beats a hit increment
   always_comb begin
      pc_inc_en_d  = 1'b1;
      pc_inc_val_d = '0;
      out_en_d     = 1'b0;
      miss_d       = 1'b0;
      bundle_d     = bundle_q;
      baddr_d      = baddr_q;
      blen_d       = blen_q;
      bpid_d       = bpid_q;
      btid_d       = btid_q;
      bmaj_d       = bmaj_q;
      maddr_d      = maddr_q;
      mmaj_d       = mmaj_q;
      mpid_d       = mpid_q;
      mtid_d       = mtid_q;
      ctr_d        = ctr_q;
      if (hit_c) begin
         out_en_d     = 1'b1;
         bundle_d     = bundle_c;
         baddr_d      = fetchAddress_i;
         blen_d       = LEN_W'(n_c - INC_W'(1));
         bpid_d       = Pid_i;
         btid_d       = Tid_i;
         bmaj_d       = ctr_q;
         ctr_d        = ctr_q + MAJ_W'(n_c);
         pc_inc_en_d  = (n_c < INC_W'(BUNDLE_INSTS));
         pc_inc_val_d = n_c;
      end else if (lookup_c) begin
         miss_d       = 1'b1;
         maddr_d      = fetchAddress_i;
         mmaj_d       = ctr_q;
         mpid_d       = Pid_i;
         mtid_d       = Tid_i;
      end
      if (cacheUpdate_i) ctr_d = missedInstMajorId_i;
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         pc_inc_en_q  <= 1'b0;
         pc_inc_val_q <= '0;
         out_en_q     <= 1'b0;
         bundle_q     <= '0;
         baddr_q      <= '0;
         blen_q       <= '0;
         bpid_q       <= '0;
         btid_q       <= '0;
         bmaj_q       <= '0;
         miss_q       <= 1'b0;
         maddr_q      <= '0;
         mmaj_q       <= '0;
         mpid_q       <= '0;
         mtid_q       <= '0;
         ctr_q        <= '0;
      end else begin
         pc_inc_en_q  <= pc_inc_en_d;
         pc_inc_val_q <= pc_inc_val_d;
         out_en_q     <= out_en_d;
         bundle_q     <= bundle_d;
         baddr_q      <= baddr_d;
         blen_q       <= blen_d;
         bpid_q       <= bpid_d;
         btid_q       <= btid_d;
         bmaj_q       <= bmaj_d;
         miss_q       <= miss_d;
         maddr_q      <= maddr_d;
         mmaj_q       <= mmaj_d;
         mpid_q       <= mpid_d;
         mtid_q       <= mtid_d;
         ctr_q        <= ctr_d;
      end
   end

   assign icachePCIncEnable_o = pc_inc_en_q;
   assign iCachePCIncVal_o    = pc_inc_val_q;
   assign outputEnable_o      = out_en_q;
   assign outputBundle_o      = bundle_q;
   assign bundleAddress_o     = baddr_q;
   assign bundleLen_o         = blen_q;
   assign bundlePid_o         = bpid_q;
   assign bundleTid_o         = btid_q;
   assign bundleStartMajId_o  = bmaj_q;
   assign cacheMiss_o         = miss_q;
   assign missedAddress_o     = maddr_q;
   assign missedInstMajorId_o = mmaj_q;
   assign missedPid_o         = mpid_q;
   assign missedTid_o         = mtid_q;

endmodule

// File: tb/tb_l1i_cache.sv
// Bench for l1i_cache: directed scenarios then random traffic against an array-based reference model.
module tb_l1i_cache;

   logic          clock_i;
   logic          reset_i;
   logic          fetchEnable_i;
   logic          cacheReset_i;
   logic          fetchStall_i;
   logic [31:0]   Pid_i;
   logic [63:0]   Tid_i;
   logic [63:0]   fetchAddress_i;
   logic          cacheUpdate_i;
   logic [63:0]   cacheUpdateAddress_i;
   logic [31:0]   cacheUpdatePid_i;
   logic [63:0]   cacheUpdateTid_i;
   logic [63:0]   missedInstMajorId_i;
   logic [511:0]  cacheUpdateLine_i;
   logic          naturalWriteEn_i;
   logic [63:0]   naturalWriteAddress_i;
   logic [511:0]  naturalWriteLine_i;
   logic [31:0]   naturalPid_i;
   logic [63:0]   naturalTid_i;
   logic          icachePCIncEnable_o;
   logic [2:0]    iCachePCIncVal_o;
   logic          outputEnable_o;
   logic [127:0]  outputBundle_o;
   logic [63:0]   bundleAddress_o;
   logic [1:0]    bundleLen_o;
   logic [31:0]   bundlePid_o;
   logic [63:0]   bundleTid_o;
   logic [63:0]   bundleStartMajId_o;
   logic          cacheMiss_o;
   logic [63:0]   missedAddress_o;
   logic [63:0]   missedInstMajorId_o;
   logic [31:0]   missedPid_o;
   logic [63:0]   missedTid_o;

   l1i_cache dut (
      .clock_i(clock_i), .reset_i(reset_i), .fetchEnable_i(fetchEnable_i),
      .cacheReset_i(cacheReset_i), .fetchStall_i(fetchStall_i), .Pid_i(Pid_i), .Tid_i(Tid_i),
      .fetchAddress_i(fetchAddress_i), .cacheUpdate_i(cacheUpdate_i),
      .cacheUpdateAddress_i(cacheUpdateAddress_i), .cacheUpdatePid_i(cacheUpdatePid_i),
      .cacheUpdateTid_i(cacheUpdateTid_i), .missedInstMajorId_i(missedInstMajorId_i),
      .cacheUpdateLine_i(cacheUpdateLine_i), .naturalWriteEn_i(naturalWriteEn_i),
      .naturalWriteAddress_i(naturalWriteAddress_i), .naturalWriteLine_i(naturalWriteLine_i),
      .naturalPid_i(naturalPid_i), .naturalTid_i(naturalTid_i),
      .icachePCIncEnable_o(icachePCIncEnable_o), .iCachePCIncVal_o(iCachePCIncVal_o),
      .outputEnable_o(outputEnable_o), .outputBundle_o(outputBundle_o),
      .bundleAddress_o(bundleAddress_o), .bundleLen_o(bundleLen_o), .bundlePid_o(bundlePid_o),
      .bundleTid_o(bundleTid_o), .bundleStartMajId_o(bundleStartMajId_o),
      .cacheMiss_o(cacheMiss_o), .missedAddress_o(missedAddress_o),
      .missedInstMajorId_o(missedInstMajorId_o), .missedPid_o(missedPid_o),
      .missedTid_o(missedTid_o)
   );

   initial begin
      clock_i = 1'b0;
      forever #5 clock_i = ~clock_i;
   end

   int checks   = 0;
   int failures = 0;

   // Reference model state
   bit           m_valid [256];
   logic [49:0]  m_tag   [256];
   logic [31:0]  m_pid   [256];
   logic [63:0]  m_tid   [256];
   logic [31:0]  m_data  [256][16];
   logic [63:0]  m_ctr;

   // Expected registered outputs
   logic          e_pcen;
   logic [2:0]    e_pcval;
   logic          e_oe;
   logic [127:0]  e_bundle;
   logic [63:0]   e_baddr;
   logic [1:0]    e_blen;
   logic [31:0]   e_bpid;
   logic [63:0]   e_btid;
   logic [63:0]   e_bmaj;
   logic          e_miss;
   logic [63:0]   e_maddr;
   logic [63:0]   e_mmaj;
   logic [31:0]   e_mpid;
   logic [63:0]   e_mtid;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      check("pc_inc_en",   128'(icachePCIncEnable_o), 128'(e_pcen));
      if (e_pcen) check("pc_inc_val", 128'(iCachePCIncVal_o), 128'(e_pcval));
      check("out_en",      128'(outputEnable_o),      128'(e_oe));
      check("bundle",      outputBundle_o,            e_bundle);
      check("bundle_addr", 128'(bundleAddress_o),     128'(e_baddr));
      check("bundle_len",  128'(bundleLen_o),         128'(e_blen));
      check("bundle_pid",  128'(bundlePid_o),         128'(e_bpid));
      check("bundle_tid",  128'(bundleTid_o),         128'(e_btid));
      check("bundle_maj",  128'(bundleStartMajId_o),  128'(e_bmaj));
      check("miss",        128'(cacheMiss_o),         128'(e_miss));
      check("miss_addr",   128'(missedAddress_o),     128'(e_maddr));
      check("miss_maj",    128'(missedInstMajorId_o), 128'(e_mmaj));
      check("miss_pid",    128'(missedPid_o),         128'(e_mpid));
      check("miss_tid",    128'(missedTid_o),         128'(e_mtid));
   endtask

   task automatic reset_model();
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_ctr = '0;
      e_pcen = 0; e_pcval = 0; e_oe = 0; e_bundle = 0; e_baddr = 0; e_blen = 0;
      e_bpid = 0; e_btid = 0; e_bmaj = 0; e_miss = 0; e_maddr = 0; e_mmaj = 0;
      e_mpid = 0; e_mtid = 0;
   endtask

   task automatic model_write(input logic [63:0] a, input logic [31:0] pid,
                              input logic [63:0] tid, input logic [511:0] line);
      int idx;
      idx = int'((a >> 6) % 64'd256);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = 50'(a >> 14);
      m_pid[idx]   = pid;
      m_tid[idx]   = tid;
      for (int k = 0; k < 16; k++) m_data[idx][k] = line[32*k +: 32];
   endtask

   // Predict the next edge from current inputs, advance the model, then compare
   task automatic cycle();
      logic        lookup, hit;
      int          idx, sl, n;
      logic [63:0] a, ctr_next;
      a      = fetchAddress_i;
      idx    = int'((a >> 6) % 64'd256);
      sl     = int'((a >> 2) % 64'd16);
      lookup = fetchEnable_i && !fetchStall_i;
      hit    = lookup && m_valid[idx] && (m_tag[idx] == 50'(a >> 14))
               && (m_pid[idx] == Pid_i) && (m_tid[idx] == Tid_i);
      ctr_next = m_ctr;
      e_oe = 0; e_miss = 0; e_pcen = 1; e_pcval = 0;
      if (hit) begin
         n = (16 - sl < 4) ? 16 - sl : 4;
         e_bundle = '0;
         for (int j = 0; j < n; j++) e_bundle[32*j +: 32] = m_data[idx][sl + j];
         e_oe = 1; e_baddr = a; e_blen = 2'(n - 1);
         e_bpid = Pid_i; e_btid = Tid_i; e_bmaj = m_ctr;
         ctr_next = m_ctr + 64'(n);
         if (n < 4) e_pcval = 3'(n);
         else       e_pcen  = 0;
      end else if (lookup) begin
         e_miss = 1; e_maddr = a; e_mmaj = m_ctr; e_mpid = Pid_i; e_mtid = Tid_i;
      end
      if (cacheUpdate_i) ctr_next = missedInstMajorId_i;
      if (cacheReset_i) begin
         foreach (m_valid[i]) m_valid[i] = 1'b0;
      end else begin
         if (naturalWriteEn_i)
            model_write(naturalWriteAddress_i, naturalPid_i, naturalTid_i, naturalWriteLine_i);
         if (cacheUpdate_i)
            model_write(cacheUpdateAddress_i, cacheUpdatePid_i, cacheUpdateTid_i, cacheUpdateLine_i);
      end
      @(posedge clock_i);
      #1;
      m_ctr = ctr_next;
      check_outputs();
   endtask

   task automatic idle_inputs();
      fetchEnable_i = 0; cacheReset_i = 0; fetchStall_i = 0; Pid_i = 0; Tid_i = 0;
      fetchAddress_i = 0; cacheUpdate_i = 0; cacheUpdateAddress_i = 0; cacheUpdatePid_i = 0;
      cacheUpdateTid_i = 0; missedInstMajorId_i = 0; cacheUpdateLine_i = 0;
      naturalWriteEn_i = 0; naturalWriteAddress_i = 0; naturalWriteLine_i = 0;
      naturalPid_i = 0; naturalTid_i = 0;
   endtask

   function automatic logic [511:0] seq_line(input logic [31:0] base);
      logic [511:0] l;
      for (int k = 0; k < 16; k++) l[32*k +: 32] = base + 32'(k);
      return l;
   endfunction

   function automatic logic [511:0] rand_line();
      logic [511:0] l;
      for (int k = 0; k < 16; k++) l[32*k +: 32] = $urandom;
      return l;
   endfunction

   function automatic logic [63:0] rand_addr();
      logic [63:0] tg, ix;
      int unsigned r;
      r  = $urandom_range(0, 2);
      tg = (r == 0) ? 64'd0 : (r == 1) ? 64'd1 : (64'd1 << 49);
      r  = $urandom_range(0, 3);
      ix = (r == 3) ? 64'd255 : 64'(r);
      return (tg << 14) | (ix << 6) | (64'($urandom_range(0, 15)) << 2) | 64'($urandom_range(0, 3));
   endfunction

   function automatic logic [63:0] rand_tid();
      return ($urandom_range(0, 3) == 0) ? 64'h8000_0000_0000_0001 : 64'($urandom_range(0, 1));
   endfunction

   initial begin
      idle_inputs();
      reset_model();
      reset_i = 1'b1;
      #1 reset_i = 1'b0;
      repeat (2) @(posedge clock_i);
      #1 check_outputs();
      @(negedge clock_i);
      reset_i = 1'b1;

      // Cold miss at address 0
      fetchEnable_i = 1; fetchAddress_i = 64'h0;
      cycle();

      // Refill line 0 with 0x1000+k, major ID 5
      fetchEnable_i = 0;
      cacheUpdate_i = 1; cacheUpdateAddress_i = 64'h0; cacheUpdateLine_i = seq_line(32'h1000);
      missedInstMajorId_i = 64'd5;
      cycle();
      cacheUpdate_i = 0;

      fetchEnable_i = 1; fetchAddress_i = 64'h0;  cycle();
      fetchAddress_i = 64'h10; cycle();
      fetchAddress_i = 64'h34; cycle();
      check("slot13_bundle", outputBundle_o, {32'h0, 32'h100F, 32'h100E, 32'h100D});

      // PID mismatch, then natural write under PID 1
      fetchAddress_i = 64'h0; Pid_i = 1; cycle();
      fetchEnable_i = 0;
      naturalWriteEn_i = 1; naturalWriteAddress_i = 64'h0; naturalPid_i = 1;
      naturalWriteLine_i = seq_line(32'h2000);
      cycle();
      naturalWriteEn_i = 0;
      fetchEnable_i = 1; cycle();

      // Bulk invalidate, then stall
      fetchEnable_i = 0; cacheReset_i = 1; cycle();
      cacheReset_i = 0; fetchEnable_i = 1; cycle();
      fetchStall_i = 1; cycle();
      fetchStall_i = 0;

      // Async reset in the middle of a hitting fetch
      fetchEnable_i = 0;
      cacheUpdate_i = 1; cacheUpdateAddress_i = 64'h0; cacheUpdatePid_i = 1;
      cacheUpdateLine_i = seq_line(32'h3000); missedInstMajorId_i = 64'd7;
      cycle();
      cacheUpdate_i = 0; fetchEnable_i = 1;
      cycle();
      #2 reset_i = 1'b0;
      #1;
      reset_model();
      check_outputs();
      @(negedge clock_i);
      reset_i = 1'b1;
      cycle();

      // Random traffic
      for (int t = 0; t < 600; t++) begin
         fetchEnable_i = ($urandom_range(0, 9) < 8);
         fetchStall_i  = ($urandom_range(0, 9) == 0);
         fetchAddress_i = rand_addr();
         Pid_i = 32'($urandom_range(0, 1));
         Tid_i = rand_tid();
         cacheReset_i  = ($urandom_range(0, 49) == 0);
         cacheUpdate_i = !cacheReset_i && ($urandom_range(0, 6) == 0);
         cacheUpdateAddress_i = rand_addr();
         cacheUpdatePid_i = 32'($urandom_range(0, 1));
         cacheUpdateTid_i = rand_tid();
         missedInstMajorId_i = {32'($urandom), 32'($urandom)};
         cacheUpdateLine_i = rand_line();
         naturalWriteEn_i = ($urandom_range(0, 5) == 0);
         naturalWriteAddress_i = ($urandom_range(0, 2) == 0) ? cacheUpdateAddress_i : rand_addr();
         naturalPid_i = 32'($urandom_range(0, 1));
         naturalTid_i = rand_tid();
         naturalWriteLine_i = rand_line();
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/l1i_cache.md
Name: l1i_cache

Overview:
- Direct-mapped L1 instruction cache inside the fetch unit.
- Each cycle it looks up the fetch address against a per-line tag, PID and TID, and returns a bundle of up to 4 consecutive instructions with a 64-bit major-ID stamp.
- On a miss it reports the miss; it is refilled by miss-resolution or natural writes.
- It tells the PC logic how far to advance when a full bundle cannot be delivered.

Parameters:
- addressWidth, 64, address bits.
- cacheLineWith, 512, line bits (64 bytes, 16 instructions).
- instructionWidth, 32, instruction bits.
- offsetWidth, 6, byte-offset bits within a line.
- indexWidth, 8, line-index bits (256 lines).
- tagWidth, 62, stored tag width. Must be >= addressWidth-indexWidth-offsetWidth (50). The tag is zero-extended into this width.
- PidSize, 32, process ID bits.
- TidSize, 64, thread ID bits.
- instructionCounterWidth, 64, major-ID bits.

Ports:
- clock_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- fetchEnable_i  in  1  request a lookup this cycle.
- cacheReset_i  in  1  invalidate all lines.
- fetchStall_i  in  1  suppress lookup.
- Pid_i  in  PidSize  current process ID.
- Tid_i  in  TidSize  current thread ID.
- fetchAddress_i  in  addressWidth  byte fetch address.
- cacheUpdate_i  in  1  miss-refill write.
- cacheUpdateAddress_i  in  addressWidth  refill address.
- cacheUpdatePid_i  in  PidSize  refill PID.
- cacheUpdateTid_i  in  TidSize  refill TID.
- missedInstMajorId_i  in  instructionCounterWidth  major ID to resume from.
- cacheUpdateLine_i  in  cacheLineWith  refill line data.
- naturalWriteEn_i  in  1  non-miss line write.
- naturalWriteAddress_i  in  addressWidth  natural-write address.
- naturalWriteLine_i  in  cacheLineWith  natural-write data.
- naturalPid_i  in  PidSize  natural-write PID.
- naturalTid_i  in  TidSize  natural-write TID.
- icachePCIncEnable_o  out  1  override the PC increment.
- iCachePCIncVal_o  out  3  override increment, in instructions.
- outputEnable_o  out  1  bundle valid.
- outputBundle_o  out  4*instructionWidth  bundle data.
- bundleAddress_o  out  addressWidth  address of the first instruction.
- bundleLen_o  out  2  valid instruction count minus 1.
- bundlePid_o  out  PidSize  PID of the bundle.
- bundleTid_o  out  TidSize  TID of the bundle.
- bundleStartMajId_o  out  instructionCounterWidth  major ID of the first instruction.
- cacheMiss_o  out  1  miss pulse.
- missedAddress_o  out  addressWidth  missed fetch address.
- missedInstMajorId_o  out  instructionCounterWidth  major ID at the miss.
- missedPid_o  out  PidSize  PID at the miss.
- missedTid_o  out  TidSize  TID at the miss.

Behaviour:
- Address fields, bit 0 = MSB:
  - tag = bits [0:49]
  - index = bits [50:57]
  - slot = bits [58:61] (instruction 0–15 in the line)
  - bits [62:63] are ignored.
- Per line: valid, tag, PID, TID and 512-bit data. Instruction k occupies line bits [32k:32k+31].
- Reset (reset_i=0, asynchronous): all valid bits, all outputs and the major-ID counter go to 0.
- All outputs are registered; latency from request to response is 1 cycle.
- A lookup happens when fetchEnable_i=1 and fetchStall_i=0.
  - Hit condition: valid & tag match & PID match & TID match.
- On a hit, at the next edge:
  - outputEnable_o=1 and cacheMiss_o=0.
  - n = min(4, 16-slot) instructions, slot..slot+n-1, packed from bundle bit 0 upward; unused slots are 0.
  - bundleLen_o=n-1.
  - bundleAddress_o=fetchAddress_i; bundlePid_o/bundleTid_o = Pid_i/Tid_i.
  - bundleStartMajId_o=counter, then counter += n.
  - If n<4: icachePCIncEnable_o=1 and iCachePCIncVal_o=n. Otherwise icachePCIncEnable_o=0.
- On a miss:
  - cacheMiss_o=1 for one cycle and outputEnable_o=0.
  - missedAddress_o=fetchAddress_i, missedInstMajorId_o=counter, missedPid_o/missedTid_o = Pid_i/Tid_i.
  - icachePCIncEnable_o=1 with iCachePCIncVal_o=0 (hold PC). The counter is unchanged.
- No lookup (disabled or stalled): outputEnable_o=0, cacheMiss_o=0, icachePCIncEnable_o=1, iCachePCIncVal_o=0. The data outputs hold their values.
- cacheUpdate_i writes line[index] with data, tag, PID, TID and valid=1, and loads the counter with missedInstMajorId_i.
- naturalWriteEn_i does the same write without touching the counter.
- Both writes to the same index in one cycle: cacheUpdate_i wins. Different indices: both are written.
- Lookup and write to the same line in one cycle: the lookup sees the old contents (read-before-write).
- cacheReset_i clears all valid bits in one cycle and takes priority over writes in that cycle. A lookup in that cycle sees the old valid bits.
- A counter-load and a hit increment in the same cycle: the load wins.

Decomposition:
- Package l1i_pkg holds the field-extraction widths, line count and bundle width constants.
- Sub-module l1i_line_store: the tag/PID/TID/valid/data arrays with 1 read port, 2 write ports and bulk invalidate.

Test Plan:
- Reset, then fetch 0x0 with Pid 0 / Tid 0 → next cycle cacheMiss_o=1, missedAddress_o=0, missedInstMajorId_o=0, iCachePCIncVal_o=0.
- cacheUpdate of line 0x0 with instructions 0..15 = 0x1000+k and missedInstMajorId_i=5, then fetch 0x0 → outputEnable_o=1, bundle 0x1000,0x1001,0x1002,0x1003, bundleLen_o=3, bundleStartMajId_o=5. A following fetch of 0x10 → bundleStartMajId_o=9.
- Fetch 0x34 (slot 13) → n=3, bundleLen_o=2, bundle 0x100D,0x100E,0x100F,0, icachePCIncEnable_o=1, iCachePCIncVal_o=3.
- Fetch 0x0 with Pid_i=1 after a refill with PID 0 → miss. Natural write with PID 1, then fetch → hit.
- Assert cacheReset_i, then fetch 0x0 → miss. Assert fetchStall_i → outputEnable_o=0 and cacheMiss_o=0.
- Drive reset_i low mid-fetch, asynchronously → outputs and counter 0 immediately; a subsequent fetch misses.
